// File: rtl/crc_pkg.sv
// Shared constants, FSM encoding and elaboration-time table helpers for the
// slicing-by-N CRC-32 engine.
package crc_pkg;

  localparam logic [31:0] POLY_CRC32_REFL    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT_DEFAULT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT_DEFAULT = 32'hFFFFFFFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } crc_state_e;

  // Width of the per-beat byte count (0..data_bytes inclusive).
  function automatic int unsigned beat_cnt_width(input int unsigned data_bytes);
    return $clog2(data_bytes + 1);
  endfunction

  // Reflected CRC of data_byte followed by shift_bytes zero bytes, zero seed,
  // no final XOR. Zero trailing bytes only clock the register, so the whole
  // entry is 8*(shift_bytes+1) plain shift/reduce steps.
  function automatic logic [31:0] crc_table_entry(input logic [31:0]  poly,
                                                  input int unsigned  shift_bytes,
                                                  input logic [7:0]   data_byte);
    logic [31:0] c;
    c = {24'd0, data_byte};
    for (int unsigned s = 0; s < 8 * (shift_bytes + 1); s++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_lut_table.sv
// 256-entry CRC lookup for one slice position, built at elaboration.
// Ports:
//   addr    in  8   table index (already XORed byte)
//   data_c  out 32  table entry, combinational
module crc_lut_table
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY_REFL   = POLY_CRC32_REFL,
  parameter int unsigned SHIFT_BYTES = 0
) (
  input  logic [7:0]  addr,
  output logic [31:0] data_c
);

  logic [31:0] rom [256];

  for (genvar b = 0; b < 256; b++) begin : g_rom
    localparam logic [31:0] ENTRY = crc_table_entry(POLY_REFL, SHIFT_BYTES, 8'(b));
    assign rom[b] = ENTRY;
  end

  assign data_c = rom[addr];

endmodule

// File: rtl/crc32_slice_engine.sv
// Pipelined slicing-by-N CRC-32 engine: input stage A, accumulator stage B,
// buffered single-entry result register.
// Ports:
//   clk, rst            clock, async active-high reset
//   s_valid/s_ready     input beat handshake (s_ready is combinational)
//   s_data              DATA_BYTES bytes, byte 0 first on the wire
//   s_keep              byte enables, used on the last beat only
//   s_last              beat ends the frame
//   m_valid/m_ready     result handshake
//   m_crc               finalised CRC of the frame
module crc32_slice_engine
  import crc_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [31:0] POLY_REFL  = POLY_CRC32_REFL,
  parameter logic [31:0] INIT       = CRC_INIT_DEFAULT,
  parameter logic [31:0] XOROUT     = CRC_XOROUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [31:0]             m_crc
);

  localparam int unsigned DW    = 8 * DATA_BYTES;
  localparam int unsigned CNT_W = beat_cnt_width(DATA_BYTES);

  // Stage A
  logic              a_valid;
  logic              a_last;
  logic [DW-1:0]     a_data;
  logic [CNT_W-1:0]  a_n;

  // Stage B
  logic [31:0]       acc;
  crc_state_e        state;
  crc_state_e        state_next;
  logic              seed_idle;

  logic              stall;
  logic              advance;
  logic [CNT_W-1:0]  keep_n;
  logic [CNT_W-1:0]  beat_n;

  logic [31:0]                  acc_cur;
  logic [DATA_BYTES-1:0][7:0]   x;
  logic [7:0]                   lut_addr [DATA_BYTES];
  logic [31:0]                  lut_data [DATA_BYTES];
  logic [31:0]                  crc_fold;
  logic [31:0]                  acc_shift;
  logic [31:0]                  acc_next;

  // Handshake: only a finished frame waiting on a full result register stalls.
  assign stall   = a_valid & a_last & m_valid & ~m_ready;
  assign advance = a_valid & ~stall;
  assign s_ready = ~a_valid | advance;

  // Byte count of the last beat: one past the highest set keep bit.
  always_comb begin
    keep_n = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_keep[i]) keep_n = CNT_W'(i + 1);
    end
  end

  assign beat_n = s_last ? keep_n : CNT_W'(DATA_BYTES);

  // Input stage A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_last  <= 1'b0;
      a_data  <= '0;
      a_n     <= '0;
    end else if (s_ready) begin
      a_valid <= s_valid;
      if (s_valid) begin
        a_data <= s_data;
        a_last <= s_last;
        a_n    <= beat_n;
      end
    end
  end

  // Frame FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Frame FSM: next state
  always_comb begin
    state_next = state;
    if (advance) state_next = a_last ? ST_IDLE : ST_ACTIVE;
  end

  // Frame FSM: outputs
  always_comb begin
    seed_idle = 1'b0;
    if (state == ST_IDLE) seed_idle = 1'b1;
  end

  assign acc_cur = seed_idle ? INIT : acc;

  // Per-lane byte mixing and table instances; table k serves shift k.
  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
    logic [7:0] d_byte;
    assign d_byte = a_data[8*i +: 8];
    if (i < 4) begin : g_mix
      assign x[i] = (32'(a_n) > 32'(i)) ? (d_byte ^ acc_cur[8*i +: 8]) : d_byte;
    end else begin : g_pass
      assign x[i] = d_byte;
    end
    crc_lut_table #(
      .POLY_REFL  (POLY_REFL),
      .SHIFT_BYTES(i)
    ) u_lut (
      .addr  (lut_addr[i]),
      .data_c(lut_data[i])
    );
  end

  // Byte i of an n-byte beat is followed by n-1-i bytes, so it feeds table n-1-i.
  always_comb begin
    crc_fold = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      lut_addr[k] = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (32'(k + i + 1) == 32'(a_n)) lut_addr[k] = x[i];
      end
    end
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (32'(k) < 32'(a_n)) crc_fold = crc_fold ^ lut_data[k];
    end
  end

  assign acc_shift = (32'(a_n) < 32'd4) ? (acc_cur >> {a_n, 3'b000}) : 32'd0;
  assign acc_next  = acc_shift ^ crc_fold;

  // Accumulator; reseeded on the edge a frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= INIT;
    end else if (advance) begin
      acc <= a_last ? INIT : acc_next;
    end
  end

  // Result register: a new result wins over a same-edge consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_crc   <= '0;
    end else if (advance && a_last) begin
      m_valid <= 1'b1;
      m_crc   <= acc_next ^ XOROUT;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc32_slice_engine.sv
// Self-checking bench: directed CRC vectors, stall/reset cases, and random
// frames against a bitwise serial CRC-32 model.
module tb_crc32_slice_engine;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s_valid4 = 1'b0, s_ready4, s_last4 = 1'b0;
  logic [31:0] s_data4 = '0;
  logic [3:0]  s_keep4 = '0;
  logic        m_valid4, m_ready4 = 1'b1;
  logic [31:0] m_crc4;

  logic        s_valid8 = 1'b0, s_ready8, s_last8 = 1'b0;
  logic [63:0] s_data8 = '0;
  logic [7:0]  s_keep8 = '0;
  logic        m_valid8, m_ready8 = 1'b1;
  logic [31:0] m_crc8;

  int checks = 0;
  int errors = 0;

  beat_t       beat_q [$];
  logic [31:0] exp_q  [$];

  always #5 clk = ~clk;

  crc32_slice_engine #(.DATA_BYTES(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .s_keep(s_keep4), .s_last(s_last4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_crc(m_crc4)
  );

  crc32_slice_engine #(.DATA_BYTES(8)) dut8 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .s_keep(s_keep8), .s_last(s_last8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_crc(m_crc8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Plain bit-serial reflected CRC-32 with standard seed and final XOR.
  function automatic logic [31:0] ref_crc(input logic [7:0] bytes [$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bytes[j]) begin
      c = c ^ {24'd0, bytes[j]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l);
    int cyc;
    cyc = 0;
    @(negedge clk);
    s_valid4 = 1'b1; s_data4 = d; s_keep4 = k; s_last4 = l;
    #1;
    while (!s_ready4 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (!s_ready4) check_eq("send4_timeout", 32'(s_ready4), 32'd1);
    @(posedge clk);
  endtask

  task automatic send8(input logic [63:0] d, input logic [7:0] k, input logic l);
    int cyc;
    cyc = 0;
    @(negedge clk);
    s_valid8 = 1'b1; s_data8 = d; s_keep8 = k; s_last8 = l;
    #1;
    while (!s_ready8 && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    if (!s_ready8) check_eq("send8_timeout", 32'(s_ready8), 32'd1);
    @(posedge clk);
  endtask

  // Called right after a last beat is accepted: result lands one edge later.
  task automatic expect4(input string tag, input logic [31:0] exp);
    @(negedge clk);
    s_valid4 = 1'b0;
    #1 check_eq({tag, "_lat_early"}, 32'(m_valid4), 32'd0);
    @(negedge clk);
    #1;
    check_eq({tag, "_valid"}, 32'(m_valid4), 32'd1);
    check_eq({tag, "_crc"}, m_crc4, exp);
  endtask

  task automatic expect8(input string tag, input logic [31:0] exp);
    @(negedge clk);
    s_valid8 = 1'b0;
    #1 check_eq({tag, "_lat_early"}, 32'(m_valid8), 32'd0);
    @(negedge clk);
    #1;
    check_eq({tag, "_valid"}, 32'(m_valid8), 32'd1);
    check_eq({tag, "_crc"}, m_crc8, exp);
  endtask

  task automatic frame_123456789();
    send4(32'h34333231, 4'hF, 1'b0);
    send4(32'h38373635, 4'hF, 1'b0);
    send4(32'h00000039, 4'h1, 1'b1);
  endtask

  function automatic void gen_frame();
    int          len;
    int          nb;
    int          rem;
    int          top;
    beat_t       bt;
    logic [7:0]  bytes [$];
    len = $urandom_range(0, 13);
    nb  = (len == 0) ? 1 : (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      rem  = len - 4 * b;
      if (rem > 4) rem = 4;
      bt.d = $urandom;
      bt.l = (b == nb - 1);
      if (bt.l) begin
        if (rem == 0) bt.k = 4'd0;
        else begin
          top  = (1 << (rem - 1));
          bt.k = 4'(top | (int'($urandom) & (top - 1)));
        end
      end else begin
        bt.k = 4'($urandom);
      end
      for (int i = 0; i < rem; i++) bytes.push_back(bt.d[8*i +: 8]);
      beat_q.push_back(bt);
    end
    exp_q.push_back(ref_crc(bytes));
  endfunction

  task automatic run_random(input int nframes);
    beat_t cur;
    bit    holding;
    int    cyc;
    holding = 1'b0;
    cyc     = 0;
    cur     = '{d: 32'd0, k: 4'd0, l: 1'b0};
    for (int f = 0; f < nframes; f++) gen_frame();
    while ((beat_q.size() > 0 || holding || exp_q.size() > 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (!holding && beat_q.size() > 0 && $urandom_range(0, 99) < 70) begin
        cur     = beat_q.pop_front();
        holding = 1'b1;
      end
      s_valid4 = holding;
      if (holding) begin
        s_data4 = cur.d; s_keep4 = cur.k; s_last4 = cur.l;
      end else begin
        s_data4 = $urandom; s_keep4 = 4'($urandom); s_last4 = 1'($urandom);
      end
      m_ready4 = ($urandom_range(0, 99) < 60);
      #1;
      if (s_valid4 && s_ready4) holding = 1'b0;
      if (m_valid4 && m_ready4) begin
        if (exp_q.size() == 0) check_eq("rand_unexpected", m_crc4, 32'hDEADBEEF ^ m_crc4 ^ 32'd1);
        else check_eq("rand_crc", m_crc4, exp_q.pop_front());
      end
    end
    if (cyc >= 30000) check_eq("rand_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    s_valid4 = 1'b0;
    m_ready4 = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_m_valid", 32'(m_valid4), 32'd0);
    check_eq("rst_m_crc", m_crc4, 32'd0);
    check_eq("rst_s_ready", 32'(s_ready4), 32'd1);
    check_eq("rst_acc", dut4.acc, 32'hFFFFFFFF);
    check_eq("rst_m_valid8", 32'(m_valid8), 32'd0);

    // Check vector with two-stage latency
    frame_123456789();
    expect4("check9", 32'hCBF43926);

    // Single zero byte and zero-length frames
    send4(32'hA5A5A500, 4'h1, 1'b1);
    expect4("byte00", 32'hD202EF8D);
    send4(32'h12345678, 4'h0, 1'b1);
    expect4("empty", 32'h00000000);

    // Two frames back to back with the result port blocked
    @(negedge clk);
    m_ready4 = 1'b0;
    frame_123456789();
    frame_123456789();
    @(negedge clk);
    s_valid4 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("stall_s_ready", 32'(s_ready4), 32'd0);
    check_eq("stall_m_valid", 32'(m_valid4), 32'd1);
    check_eq("stall_first", m_crc4, 32'hCBF43926);
    @(negedge clk);
    check_eq("stall_held", m_crc4, 32'hCBF43926);
    m_ready4 = 1'b1;
    #1 check_eq("release_s_ready", 32'(s_ready4), 32'd1);
    @(negedge clk);
    #1;
    check_eq("second_valid", 32'(m_valid4), 32'd1);
    check_eq("second_crc", m_crc4, 32'hCBF43926);
    @(negedge clk);
    #1 check_eq("drained_valid", 32'(m_valid4), 32'd0);

    // Reset in the middle of a frame
    send4(32'h34333231, 4'hF, 1'b0);
    @(negedge clk);
    s_valid4 = 1'b0;
    rst = 1'b1;
    #1 check_eq("midrst_m_valid", 32'(m_valid4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_acc", dut4.acc, 32'hFFFFFFFF);
    check_eq("midrst_a_valid", 32'(dut4.a_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1 check_eq("midrst_no_spurious", 32'(m_valid4), 32'd0);
    frame_123456789();
    expect4("after_rst", 32'hCBF43926);

    // Eight-byte beats
    send8(64'h3837363534333231, 8'hFF, 1'b0);
    send8(64'hFFFFFFFFFFFFFF39, 8'h01, 1'b1);
    expect8("w8_check9", 32'hCBF43926);
    send8(64'h0123456789ABCD00, 8'h01, 1'b1);
    expect8("w8_byte00", 32'hD202EF8D);

    // Random traffic against the serial model
    @(negedge clk);
    run_random(300);
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
